spi_slave: RTL and testbench
============================

# spi_slave

Byte-oriented SPI slave, mode 0 (CPOL=0, CPHA=0), MSB first, sitting between the external SPI master pins and the diagnostics command state machine. It oversamples SCLK, CS_n and MOSI in the single system clock domain. Each received byte is delivered as a one-cycle strobe. The byte to be returned on MISO during the following transfer is staged by a one-cycle load strobe.

## Interface
- SYNC_STAGES, 2: synchronizer flops on i_SPI_Clk, i_SPI_CS_n, i_SPI_MOSI (≥2).
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst  in  1  reset, synchronous and active-high.
- o_RX_DV  out  1  one-cycle strobe: o_RX_Byte valid.
- o_RX_Byte  out  8  last complete byte received on MOSI.
- i_TX_DV  in  1  one-cycle strobe: stage i_TX_Byte for transmission.
- i_TX_Byte  in  8  byte to transmit.
- i_SPI_Clk  in  1  SCLK from master, asynchronous.
- o_SPI_MISO  out  1  serial data to master.
- i_SPI_MOSI  in  1  serial data from master, asynchronous.
- i_SPI_CS_n  in  1  chip select, active-low, asynchronous.

## Operation
- Pin inputs pass through SYNC_STAGES flops, then one history flop for edge detection on SCLK and CS_n.
- RX: on each synchronized SCLK rising edge while CS_n low, shift MOSI into the RX shift register MSB first and increment a 3-bit bit counter. When the counter wraps 7→0, copy the shift register to o_RX_Byte and pulse o_RX_DV for exactly one i_Clk.
- TX: i_TX_DV copies i_TX_Byte into the staging register and sets the pending flag. At each byte start (CS_n falling, or the 8th SCLK rising edge with CS_n still low), move the staging register to the TX shift register and clear pending. If nothing is pending, retransmit the last staged byte.
- MISO shows bit 7 of the TX shift register at byte start. On each synchronized SCLK falling edge it advances to the next bit (7→0).
- CS_n rising mid-byte: clear the bit counter, discard the partial byte, no o_RX_DV.
- o_RX_DV never asserts while CS_n is high.
- SCLK edges while CS_n is high are ignored.
- i_TX_DV and a byte-start event in the same cycle: the new i_TX_Byte is used for that byte.
- Reset values: o_RX_DV=0, o_RX_Byte=0x00, staging=0x00, pending=0, bit counter=0, synchronizers idle (CS_n=1, SCLK=0). o_SPI_MISO is given under Configuration.
- Reset mid-transfer aborts the byte. Reception resumes at the next CS_n falling edge.

## Timing
- o_RX_DV asserts SYNC_STAGES+1 i_Clk cycles after the first i_Clk edge that samples the 8th SCLK high. With the default, that is 3 cycles.
- A staged byte must be loaded at least SYNC_STAGES+2 i_Clk before the byte-start event that uses it.
- Single-cycle i_TX_DV issued one cycle after o_RX_DV is valid for the next back-to-back byte at supported rates.
- Required: i_Clk ≥ 8× SCLK frequency. SCLK high/low each ≥ 4 i_Clk.
- MISO changes SYNC_STAGES+1 i_Clk after the SCLK falling edge. It must be stable before the master's next rising sample.
- o_RX_Byte holds until the next completed byte.

## Configuration
- SPI_MISO_TRISTATE_EN defined: o_SPI_MISO is 1'bz while synchronized CS_n is high, and driven while CS_n is low.
- SPI_MISO_TRISTATE_EN undefined: o_SPI_MISO always driven. It is 1 while CS_n is high and in reset.
- With the macro, the reset value of o_SPI_MISO is z.

## Structure
- Package spi_slave_pkg: BITS_PER_BYTE=8, SPI_BIT_CNT_W=3, RX/TX byte typedef (logic [7:0]).
- Sub-module spi_sync: SYNC_STAGES-deep synchronizer with a reset value parameter. Instantiated for SCLK (reset 0), CS_n (reset 1) and MOSI (reset 0).

## Test plan
- Stage 0xA5, lower CS_n, clock MOSI=0x3C → MISO bits 1,0,1,0,0,1,0,1; one o_RX_DV pulse; o_RX_Byte=0x3C.
- Three back-to-back bytes under one CS_n (0x66, 0x00, 0x00), with i_TX_DV=0x11 then 0x22 one cycle after each o_RX_DV → MISO carries 0xA5, 0x11, 0x22; RX bytes 0x66, 0x00, 0x00; exactly three strobes, each one cycle.
- No TX load between bytes after 0x5A was staged → 0x5A retransmitted.
- Raise CS_n after 5 bits, then send a full 0x99 → no strobe for the partial byte; one strobe with 0x99.
- Assert i_Rst mid-byte → o_RX_DV=0, o_RX_Byte=0x00, staging 0x00. The next full transfer receives correctly and MISO sends 0x00.
- CS_n high, toggle SCLK 16 times → no o_RX_DV. MISO is z with SPI_MISO_TRISTATE_EN, 1 without.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared constants and byte type for the SPI slave and its synchronizers.
package spi_slave_pkg;

    localparam int BITS_PER_BYTE = 8;
    localparam int SPI_BIT_CNT_W = 3;
    localparam logic [SPI_BIT_CNT_W-1:0] LAST_BIT = SPI_BIT_CNT_W'(BITS_PER_BYTE - 1);

    typedef logic [BITS_PER_BYTE-1:0] spi_byte_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with a configurable idle (reset) level.
module spi_sync
    import spi_slave_pkg::*;
#(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Async,
    output logic o_Sync
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_Async};
        end
    end

    assign o_Sync = r_sync[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI mode-0 slave, oversampled in the i_Clk domain.
// Define SPI_MISO_TRISTATE_EN to float o_SPI_MISO while chip select is inactive.
module spi_slave
    import spi_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                     i_Clk,
    input  logic                     i_Rst,
    output logic                     o_RX_DV,
    output logic [BITS_PER_BYTE-1:0] o_RX_Byte,
    input  logic                     i_TX_DV,
    input  logic [BITS_PER_BYTE-1:0] i_TX_Byte,
    input  logic                     i_SPI_Clk,
    output logic                     o_SPI_MISO,
    input  logic                     i_SPI_MOSI,
    input  logic                     i_SPI_CS_n
);

    logic w_sclk;
    logic w_csn;
    logic w_mosi;

    logic r_sclkPrev;
    logic r_csnPrev;
    logic r_sclkRise;
    logic r_sclkFall;
    logic r_csFall;

    logic [SPI_BIT_CNT_W-1:0] r_bitCnt;
    spi_byte_t                r_rxShift;
    spi_byte_t                w_rxNext;

    spi_byte_t r_staging;
    spi_byte_t r_txShift;
    spi_byte_t w_txNext;
    logic      r_txArmed;
    logic      w_byteEnd;
    logic      w_byteStart;
    logic      w_lateLoad;

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_syncSclk (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_Clk), .o_Sync(w_sclk)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_syncCsn (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_CS_n), .o_Sync(w_csn)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_syncMosi (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_MOSI), .o_Sync(w_mosi)
    );

    // Edge strobes are registered, so every SCLK/CS_n action lands SYNC_STAGES+1 cycles after the pin.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_sclkPrev <= 1'b0;
            r_csnPrev  <= 1'b1;
            r_sclkRise <= 1'b0;
            r_sclkFall <= 1'b0;
            r_csFall   <= 1'b0;
        end else begin
            r_sclkPrev <= w_sclk;
            r_csnPrev  <= w_csn;
            r_sclkRise <= w_sclk & ~r_sclkPrev & ~w_csn;
            r_sclkFall <= ~w_sclk & r_sclkPrev & ~w_csn;
            r_csFall   <= ~w_csn & r_csnPrev;
        end
    end

    assign w_rxNext = {r_rxShift[BITS_PER_BYTE-2:0], w_mosi};

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_bitCnt  <= '0;
            r_rxShift <= '0;
            o_RX_DV   <= 1'b0;
            o_RX_Byte <= '0;
        end else begin
            o_RX_DV <= 1'b0;
            if (w_csn) begin
                r_bitCnt <= '0;
            end else if (r_sclkRise) begin
                r_rxShift <= w_rxNext;
                r_bitCnt  <= r_bitCnt + SPI_BIT_CNT_W'(1);
                if (r_bitCnt == LAST_BIT) begin
                    o_RX_Byte <= w_rxNext;
                    o_RX_DV   <= 1'b1;
                end
            end
        end
    end

    // A load arriving just after a back-to-back byte boundary, before the first SCLK fall,
    // still replaces the byte that is about to go out.
    assign w_byteEnd   = r_sclkRise && !w_csn && (r_bitCnt == LAST_BIT);
    assign w_byteStart = r_csFall || w_byteEnd;
    assign w_lateLoad  = i_TX_DV && r_txArmed && !w_csn;
    assign w_txNext    = i_TX_DV ? i_TX_Byte : r_staging;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_staging <= '0;
            r_txShift <= '0;
            r_txArmed <= 1'b0;
        end else begin
            if (i_TX_DV) begin
                r_staging <= i_TX_Byte;
            end
            if (w_byteStart || w_lateLoad) begin
                r_txShift <= w_txNext;
            end else if (r_sclkFall && (r_bitCnt != '0)) begin
                r_txShift <= {r_txShift[BITS_PER_BYTE-2:0], 1'b0};
            end
            if (w_byteEnd) begin
                r_txArmed <= 1'b1;
            end else if (r_sclkFall || w_csn) begin
                r_txArmed <= 1'b0;
            end
        end
    end

`ifdef SPI_MISO_TRISTATE_EN
    assign o_SPI_MISO = (i_Rst || w_csn) ? 1'bz : r_txShift[BITS_PER_BYTE-1];
`else
    assign o_SPI_MISO = (i_Rst || w_csn) ? 1'b1 : r_txShift[BITS_PER_BYTE-1];
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed testbench for spi_slave: acts as a mode-0 SPI master and checks RX strobes and MISO bytes.
module tb_spi_slave;

    localparam int HALF = 8;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       i_TX_DV;
    logic [7:0] i_TX_Byte;
    logic       i_SPI_Clk;
    logic       o_SPI_MISO;
    logic       i_SPI_MOSI;
    logic       i_SPI_CS_n;

    int vecCount  = 0;
    int missCount = 0;

    int         dvCount   = 0;
    int         wideCount = 0;
    logic       prevDv    = 1'b0;
    logic [7:0] rxLog[$];

    spi_slave #(.SYNC_STAGES(2)) dut (
        .i_Clk      (i_Clk),
        .i_Rst      (i_Rst),
        .o_RX_DV    (o_RX_DV),
        .o_RX_Byte  (o_RX_Byte),
        .i_TX_DV    (i_TX_DV),
        .i_TX_Byte  (i_TX_Byte),
        .i_SPI_Clk  (i_SPI_Clk),
        .o_SPI_MISO (o_SPI_MISO),
        .i_SPI_MOSI (i_SPI_MOSI),
        .i_SPI_CS_n (i_SPI_CS_n)
    );

    always #5 i_Clk = ~i_Clk;

    // Records every RX strobe and flags strobes longer than one cycle.
    always @(negedge i_Clk) begin
        if (o_RX_DV === 1'b1) begin
            dvCount++;
            rxLog.push_back(o_RX_Byte);
            if (prevDv === 1'b1) wideCount++;
        end
        prevDv = o_RX_DV;
    end

    task automatic loadTx(input logic [7:0] b);
        @(negedge i_Clk);
        i_TX_DV   = 1'b1;
        i_TX_Byte = b;
        @(negedge i_Clk);
        i_TX_DV   = 1'b0;
    endtask

    task automatic csLow();
        @(negedge i_Clk);
        i_SPI_CS_n = 1'b0;
        repeat (HALF) @(negedge i_Clk);
    endtask

    task automatic csHigh();
        repeat (HALF) @(negedge i_Clk);
        i_SPI_CS_n = 1'b1;
        repeat (HALF) @(negedge i_Clk);
    endtask

    task automatic spiXfer(input logic [7:0] mosiByte, input int nBits, output logic [7:0] misoByte);
        misoByte = 8'h00;
        for (int i = 7; i > 7 - nBits; i--) begin
            i_SPI_MOSI = mosiByte[i];
            repeat (HALF) @(negedge i_Clk);
            misoByte[i] = o_SPI_MISO;
            i_SPI_Clk = 1'b1;
            repeat (HALF) @(negedge i_Clk);
            i_SPI_Clk = 1'b0;
        end
    endtask

    task automatic test_reset();
        i_Rst = 1'b1;
        repeat (4) @(negedge i_Clk);
        i_Rst = 1'b0;
        @(negedge i_Clk);
        vecCount++;
        if (o_RX_DV !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL reset_rx_dv: got %b expected 0", o_RX_DV);
        end
        vecCount++;
        if (o_RX_Byte !== 8'h00) begin
            missCount++;
            $display("[TB] FAIL reset_rx_byte: got %h expected 00", o_RX_Byte);
        end
        vecCount++;
`ifdef SPI_MISO_TRISTATE_EN
        if (o_SPI_MISO !== 1'bz) begin
            missCount++;
            $display("[TB] FAIL reset_miso: got %b expected z", o_SPI_MISO);
        end
`else
        if (o_SPI_MISO !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL reset_miso: got %b expected 1", o_SPI_MISO);
        end
`endif
    endtask

    task automatic test_single();
        logic [7:0] m;
        int base;
        base = dvCount;
        loadTx(8'hA5);
        csLow();
        spiXfer(8'h3C, 8, m);
        csHigh();
        vecCount++;
        if (m !== 8'hA5) begin
            missCount++;
            $display("[TB] FAIL single_miso: got %h expected a5", m);
        end
        vecCount++;
        if (dvCount - base !== 1) begin
            missCount++;
            $display("[TB] FAIL single_strobes: got %0d expected 1", dvCount - base);
        end
        vecCount++;
        if (o_RX_Byte !== 8'h3C) begin
            missCount++;
            $display("[TB] FAIL single_rx_byte: got %h expected 3c", o_RX_Byte);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m[3];
        logic [7:0] txVals[2];
        logic [7:0] expMiso[3];
        logic [7:0] expRx[3];
        logic [7:0] got;
        int base;
        int qBase;
        txVals  = '{8'h11, 8'h22};
        expMiso = '{8'hA5, 8'h11, 8'h22};
        expRx   = '{8'h66, 8'h00, 8'h00};
        base    = dvCount;
        qBase   = rxLog.size();
        loadTx(8'hA5);
        csLow();
        fork
            begin
                spiXfer(8'h66, 8, m[0]);
                spiXfer(8'h00, 8, m[1]);
                spiXfer(8'h00, 8, m[2]);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    int t;
                    t = 0;
                    while (o_RX_DV !== 1'b1 && t < 400) begin
                        @(negedge i_Clk);
                        t++;
                    end
                    vecCount++;
                    if (o_RX_DV !== 1'b1) begin
                        missCount++;
                        $display("[TB] FAIL b2b_dv_timeout: got no strobe, expected strobe %0d", k);
                    end
                    @(negedge i_Clk);
                    i_TX_DV   = 1'b1;
                    i_TX_Byte = txVals[k];
                    @(negedge i_Clk);
                    i_TX_DV   = 1'b0;
                end
            end
        join
        csHigh();
        for (int k = 0; k < 3; k++) begin
            vecCount++;
            if (m[k] !== expMiso[k]) begin
                missCount++;
                $display("[TB] FAIL b2b_miso%0d: got %h expected %h", k, m[k], expMiso[k]);
            end
            got = (rxLog.size() > qBase + k) ? rxLog[qBase + k] : 8'hxx;
            vecCount++;
            if (got !== expRx[k]) begin
                missCount++;
                $display("[TB] FAIL b2b_rx%0d: got %h expected %h", k, got, expRx[k]);
            end
        end
        vecCount++;
        if (dvCount - base !== 3) begin
            missCount++;
            $display("[TB] FAIL b2b_strobes: got %0d expected 3", dvCount - base);
        end
        vecCount++;
        if (wideCount !== 0) begin
            missCount++;
            $display("[TB] FAIL strobe_width: got %0d wide strobes expected 0", wideCount);
        end
    endtask

    task automatic test_retransmit();
        logic [7:0] m0;
        logic [7:0] m1;
        loadTx(8'h5A);
        csLow();
        spiXfer(8'h01, 8, m0);
        spiXfer(8'h02, 8, m1);
        csHigh();
        vecCount++;
        if (m0 !== 8'h5A) begin
            missCount++;
            $display("[TB] FAIL retx_first: got %h expected 5a", m0);
        end
        vecCount++;
        if (m1 !== 8'h5A) begin
            missCount++;
            $display("[TB] FAIL retx_second: got %h expected 5a", m1);
        end
        vecCount++;
        if (o_RX_Byte !== 8'h02) begin
            missCount++;
            $display("[TB] FAIL retx_rx_byte: got %h expected 02", o_RX_Byte);
        end
    endtask

    task automatic test_abort();
        logic [7:0] m;
        int base;
        base = dvCount;
        csLow();
        spiXfer(8'hFF, 5, m);
        csHigh();
        vecCount++;
        if (dvCount !== base) begin
            missCount++;
            $display("[TB] FAIL abort_partial: got %0d strobes expected 0", dvCount - base);
        end
        csLow();
        spiXfer(8'h99, 8, m);
        csHigh();
        vecCount++;
        if (dvCount - base !== 1) begin
            missCount++;
            $display("[TB] FAIL abort_full_strobes: got %0d expected 1", dvCount - base);
        end
        vecCount++;
        if (o_RX_Byte !== 8'h99) begin
            missCount++;
            $display("[TB] FAIL abort_rx_byte: got %h expected 99", o_RX_Byte);
        end
    endtask

    task automatic test_reset_midbyte();
        logic [7:0] m;
        int base;
        loadTx(8'h77);
        csLow();
        spiXfer(8'hF0, 4, m);
        @(negedge i_Clk);
        i_Rst = 1'b1;
        repeat (3) @(negedge i_Clk);
        vecCount++;
        if (o_RX_DV !== 1'b0) begin
            missCount++;
            $display("[TB] FAIL midrst_rx_dv: got %b expected 0", o_RX_DV);
        end
        vecCount++;
        if (o_RX_Byte !== 8'h00) begin
            missCount++;
            $display("[TB] FAIL midrst_rx_byte: got %h expected 00", o_RX_Byte);
        end
        i_Rst = 1'b0;
        repeat (4) @(negedge i_Clk);
        csHigh();
        base = dvCount;
        csLow();
        spiXfer(8'hC3, 8, m);
        csHigh();
        vecCount++;
        if (m !== 8'h00) begin
            missCount++;
            $display("[TB] FAIL midrst_miso: got %h expected 00", m);
        end
        vecCount++;
        if (o_RX_Byte !== 8'hC3) begin
            missCount++;
            $display("[TB] FAIL midrst_rx_after: got %h expected c3", o_RX_Byte);
        end
        vecCount++;
        if (dvCount - base !== 1) begin
            missCount++;
            $display("[TB] FAIL midrst_strobes: got %0d expected 1", dvCount - base);
        end
    endtask

    task automatic test_idle_sclk();
        int base;
        base = dvCount;
        for (int k = 0; k < 16; k++) begin
            i_SPI_MOSI = k[0];
            i_SPI_Clk  = 1'b1;
            repeat (4) @(negedge i_Clk);
            i_SPI_Clk  = 1'b0;
            repeat (4) @(negedge i_Clk);
        end
        repeat (HALF) @(negedge i_Clk);
        vecCount++;
        if (dvCount !== base) begin
            missCount++;
            $display("[TB] FAIL idle_strobes: got %0d expected 0", dvCount - base);
        end
        vecCount++;
        if (o_RX_Byte !== 8'hC3) begin
            missCount++;
            $display("[TB] FAIL idle_rx_byte: got %h expected c3", o_RX_Byte);
        end
        vecCount++;
`ifdef SPI_MISO_TRISTATE_EN
        if (o_SPI_MISO !== 1'bz) begin
            missCount++;
            $display("[TB] FAIL idle_miso: got %b expected z", o_SPI_MISO);
        end
`else
        if (o_SPI_MISO !== 1'b1) begin
            missCount++;
            $display("[TB] FAIL idle_miso: got %b expected 1", o_SPI_MISO);
        end
`endif
    endtask

    initial begin
        i_Rst      = 1'b1;
        i_TX_DV    = 1'b0;
        i_TX_Byte  = 8'h00;
        i_SPI_Clk  = 1'b0;
        i_SPI_MOSI = 1'b0;
        i_SPI_CS_n = 1'b1;
        $display("[TB] starting spi_slave directed tests");
        test_reset();
        test_single();
        test_back_to_back();
        test_retransmit();
        test_abort();
        test_reset_midbyte();
        test_idle_sclk();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
